// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter in front of a single data memory with a combinational
//   read port. The core port and the debug/loader port compete for the
//   memory; grants are combinational from the registered arbitration state
//   and the current requests. Under contention the current owner keeps the
//   memory for up to MAX_BURST consecutive grants. After that the other
//   port gets it. From idle, contention is resolved round-robin.
//   Read data is captured at the grant edge and returned one cycle later.
//
// Ports
//   clk                  : clock, all state updates on rising edge
//   rst                  : asynchronous reset, active low
//   core_req/we/mode     : core request, write enable, byte/word mode
//   core_addr/wdata      : core address and write data
//   dbg_req/we/mode      : debug port request, write enable, byte/word mode
//   dbg_addr/wdata       : debug address and write data
//   core_gnt/dbg_gnt     : access taken this cycle
//   core_rvalid/rdata    : registered read return to the core
//   dbg_rvalid/rdata     : registered read return to the debug port
//   core_stall           : core is requesting but not granted (PC hold)
//   mem_addr/wdata/we/mode : memory-side command
//   mem_rdata            : memory read data (combinational)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic                  core_mode,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic                  dbg_mode,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  core_gnt,
  output logic                  dbg_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  core_stall,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_mode,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  // Encoding of the last-granted flag
  localparam logic LAST_CORE = 1'b0;
  localparam logic LAST_DBG  = 1'b1;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  owner_t                owner_reg, owner_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic                  last_reg, last_next;
  logic                  core_rvalid_reg, core_rvalid_next;
  logic                  dbg_rvalid_reg, dbg_rvalid_next;
  logic [DATA_WIDTH-1:0] core_rdata_reg, core_rdata_next;
  logic [DATA_WIDTH-1:0] dbg_rdata_reg, dbg_rdata_next;
  logic [3:0]            cnt_inc;

  // Grant decision: purely combinational from registered state + requests
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (core_req && !dbg_req) begin
      core_gnt = 1'b1;
    end else if (dbg_req && !core_req) begin
      dbg_gnt = 1'b1;
    end else if (core_req && dbg_req) begin
      unique case (owner_reg)
        OWN_CORE: begin
          if (cnt_reg < BURST_LIMIT) core_gnt = 1'b1;
          else                       dbg_gnt  = 1'b1;
        end
        OWN_DBG: begin
          if (cnt_reg < BURST_LIMIT) dbg_gnt  = 1'b1;
          else                       core_gnt = 1'b1;
        end
        default: begin
          // Round-robin from idle: favour whoever did not go last
          if (last_reg == LAST_DBG) core_gnt = 1'b1;
          else                      dbg_gnt  = 1'b1;
        end
      endcase
    end
  end

  assign core_stall = core_req & ~core_gnt;

  // Memory mux defaults to the core side when nobody is granted
  assign mem_addr  = dbg_gnt ? dbg_addr  : core_addr;
  assign mem_wdata = dbg_gnt ? dbg_wdata : core_wdata;
  assign mem_mode  = dbg_gnt ? dbg_mode  : core_mode;
  // Grants remain live during reset, so the write strobe is gated by rst
  assign mem_we    = rst & ((core_gnt & core_we) | (dbg_gnt & dbg_we));

  assign cnt_inc = (cnt_reg == 4'hF) ? 4'hF : cnt_reg + 4'd1;

  // Next-state logic
  always_comb begin
    owner_next       = OWN_IDLE;
    cnt_next         = 4'd0;
    last_next        = last_reg;
    core_rvalid_next = 1'b0;
    dbg_rvalid_next  = 1'b0;
    core_rdata_next  = core_rdata_reg;
    dbg_rdata_next   = dbg_rdata_reg;
    if (core_gnt) begin
      owner_next = OWN_CORE;
      last_next  = LAST_CORE;
      cnt_next   = (owner_reg == OWN_CORE) ? cnt_inc : 4'd1;
      if (!core_we) begin
        core_rvalid_next = 1'b1;
        core_rdata_next  = mem_rdata;
      end
    end else if (dbg_gnt) begin
      owner_next = OWN_DBG;
      last_next  = LAST_DBG;
      cnt_next   = (owner_reg == OWN_DBG) ? cnt_inc : 4'd1;
      if (!dbg_we) begin
        dbg_rvalid_next = 1'b1;
        dbg_rdata_next  = mem_rdata;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_reg       <= OWN_IDLE;
      cnt_reg         <= 4'd0;
      last_reg        <= LAST_DBG;
      core_rvalid_reg <= 1'b0;
      dbg_rvalid_reg  <= 1'b0;
      core_rdata_reg  <= '0;
      dbg_rdata_reg   <= '0;
    end else begin
      owner_reg       <= owner_next;
      cnt_reg         <= cnt_next;
      last_reg        <= last_next;
      core_rvalid_reg <= core_rvalid_next;
      dbg_rvalid_reg  <= dbg_rvalid_next;
      core_rdata_reg  <= core_rdata_next;
      dbg_rdata_reg   <= dbg_rdata_next;
    end
  end

  assign core_rvalid = core_rvalid_reg;
  assign dbg_rvalid  = dbg_rvalid_reg;
  assign core_rdata  = core_rdata_reg;
  assign dbg_rdata   = dbg_rdata_reg;

endmodule
